// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner sequencing for the shared 16-bit datapath bus.
// Grants one of four sources (A=PC, B=MDR, C=ALU, D=MARMUX) with a bounded hold time
// and a mandatory one-cycle idle gap between owners.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous active-low reset
//   Req[3:0]     level-sensitive requests, bit0=A .. bit3=D
//   Gate[3:0]    registered one-hot bus select, 0 when no owner
//   Grant_valid  registered, high exactly when Gate is non-zero
//   Owner[1:0]   registered index of the current or most recent owner
//   Preempt      registered pulse during the gap that follows a forced release
module bus_gate_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Req,
    output logic [3:0] Gate,
    output logic       Grant_valid,
    output logic [1:0] Owner,
    output logic       Preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gate_d;
    logic             gv_d;
    logic [1:0]       owner_d;
    logic             pre_d;

    logic [1:0]       winner_c;
    logic             any_req_c;
    logic             others_c;
    logic             gate_ok_c;

    // Round-robin winner: first set request scanning ptr, ptr+1, ... (mod 4).
    // Scanning from the far end lets the closest hit overwrite earlier ones.
    always_comb begin
        winner_c = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (Req[ptr_q + 2'(i)]) begin
                winner_c = ptr_q + 2'(i);
            end
        end
    end

    assign any_req_c = |Req;
    assign others_c  = |(Req & ~(4'b0001 << Owner));
    // Gate must be one-hot and agree with Owner; anything else is a corrupted state.
    assign gate_ok_c = (Gate != 4'd0) && ((Gate & (Gate - 4'd1)) == 4'd0)
                       && (Gate == (4'b0001 << Owner));

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gate_d  = Gate;
        gv_d    = Grant_valid;
        owner_d = Owner;
        pre_d   = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                if (any_req_c) begin
                    state_d = GRANT;
                    owner_d = winner_c;
                    gate_d  = 4'b0001 << winner_c;
                    gv_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    gate_d  = 4'd0;
                    gv_d    = 1'b0;
                end
            end
            GRANT: begin
                if (!gate_ok_c) begin
                    state_d = IDLE;
                    gate_d  = 4'd0;
                    gv_d    = 1'b0;
                end else if (!Req[Owner]) begin
                    state_d = GAP;
                    gate_d  = 4'd0;
                    gv_d    = 1'b0;
                    ptr_d   = Owner + 2'd1;
                end else if ((cnt_q == HOLD_LAST) && others_c) begin
                    state_d = GAP;
                    gate_d  = 4'd0;
                    gv_d    = 1'b0;
                    ptr_d   = Owner + 2'd1;
                    pre_d   = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 4'd0;
                gv_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            Gate        <= 4'd0;
            Grant_valid <= 1'b0;
            Owner       <= 2'd0;
            Preempt     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            Gate        <= gate_d;
            Grant_valid <= gv_d;
            Owner       <= owner_d;
            Preempt     <= pre_d;
        end
    end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Testbench for bus_gate_arbiter: directed vector table, hand-written
// round-robin / lone-holder / MAX_HOLD=1 sequences, and a random invariant run.
module tb_bus_gate_arbiter;

    logic       Clk;
    logic       Reset;
    logic [3:0] Req;
    logic [3:0] Gate;
    logic       Grant_valid;
    logic [1:0] Owner;
    logic       Preempt;

    logic [3:0] req1;
    logic [3:0] gate1;
    logic       gv1;
    logic [1:0] owner1;
    logic       pre1;

    int total_cnt = 0;
    int pass_cnt  = 0;

    bus_gate_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req),
        .Gate(Gate), .Grant_valid(Grant_valid), .Owner(Owner), .Preempt(Preempt)
    );

    bus_gate_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(req1),
        .Gate(gate1), .Grant_valid(gv1), .Owner(owner1), .Preempt(pre1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gate;
        logic       gv;
        logic [1:0] owner;
        logic       pre;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vt [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] g, input logic gv,
                              input logic [1:0] o, input logic p);
        check({tag, ".gate"},  32'(Gate), 32'(g));
        check({tag, ".gv"},    32'(Grant_valid), 32'(gv));
        check({tag, ".owner"}, 32'(Owner), 32'(o));
        check({tag, ".pre"},   32'(Preempt), 32'(p));
    endtask

    logic [3:0] prev_gate;
    logic [3:0] g1;
    logic [3:0] exp_g;

    initial begin
        Reset = 1'b0;
        Req   = 4'd0;
        req1  = 4'd0;

        //            rst   req      gate     gv    own   pre
        vt[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}; // reset
        vt[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[2]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}; // idle
        vt[3]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0}; // C granted
        vt[4]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[5]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[6]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[7]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0}; // release -> gap
        vt[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0}; // idle, ptr=3
        vt[9]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0}; // B granted
        vt[10] = '{1'b1, 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b0}; // D waits
        vt[11] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 2'd1, 1'b0}; // B drops -> gap
        vt[12] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0}; // D granted
        vt[13] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0}; // gap, ptr=0
        vt[14] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0}; // A granted
        vt[15] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
        vt[16] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}; // gap, ptr=1
        vt[17] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0}; // D granted
        vt[18] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0}; // reset mid-grant
        vt[19] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0}; // D again, 1-cycle latency
        vt[20] = '{1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0}; // others ignored mid-grant
        vt[21] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};
        vt[22] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            Reset = vt[i].rst;
            Req   = vt[i].req;
            step();
            check_main($sformatf("vec%0d", i), vt[i].gate, vt[i].gv, vt[i].owner, vt[i].pre);
        end

        // Round-robin with all four requesting: A,B,C,D,A, 8 cycles each, preempt gaps.
        Reset = 1'b0;
        Req   = 4'd0;
        step();
        Reset = 1'b1;
        Req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            for (int c = 0; c < 8; c++) begin
                step();
                check_main($sformatf("rr%0d_c%0d", g, c), exp_g, 1'b1, 2'(g % 4), 1'b0);
            end
            if (g < 4) begin
                step();
                check_main($sformatf("rr%0d_gap", g), 4'd0, 1'b0, 2'(g % 4), 1'b1);
            end
        end

        // Lone holder keeps the bus; MAX_HOLD=1 instance alternates A/B with preempt gaps.
        Reset = 1'b0;
        Req   = 4'd0;
        req1  = 4'd0;
        step();
        Reset = 1'b1;
        Req   = 4'b0001;
        req1  = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            step();
            check_main($sformatf("lone_c%0d", c), 4'b0001, 1'b1, 2'd0, 1'b0);
            case (c % 4)
                0:       g1 = 4'b0001;
                2:       g1 = 4'b0010;
                default: g1 = 4'b0000;
            endcase
            check($sformatf("mh1_c%0d.gate", c),  32'(gate1),  32'(g1));
            check($sformatf("mh1_c%0d.pre", c),   32'(pre1),   32'((c % 2) == 1));
            check($sformatf("mh1_c%0d.owner", c), 32'(owner1), 32'((c % 4) >= 2));
        end
        req1 = 4'd0;

        // Random requests: one-hot/zero Gate, Grant_valid tracks Gate, gap between owners.
        Reset = 1'b0;
        Req   = 4'd0;
        step();
        Reset = 1'b1;
        prev_gate = 4'd0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(3) == 0) Req = 4'($urandom_range(15));
            step();
            check("rand.onehot", 32'((Gate & (Gate - 4'd1)) == 4'd0), 32'd1);
            check("rand.gv", 32'(Grant_valid), 32'(|Gate));
            check("rand.gap", 32'((prev_gate != 4'd0) && (Gate != 4'd0) && (Gate != prev_gate)),
                  32'd0);
            prev_gate = Gate;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
